// File: rtl/vmba_host_seq_pkg.sv
// Shared types and constants for the VMBA host-side sequencer.
// Holds op codes, R3CTRL bit positions, FSM states and parameter helpers.
package vmba_host_seq_pkg;

    typedef enum logic [1:0] {
        OP_WR  = 2'b00,
        OP_RD  = 2'b01,
        OP_RST = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    localparam int B_LD     = 0;
    localparam int B_OE     = 1;
    localparam int B_DEVRST = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [7:0] ctrl_bit(input int idx);
        return 8'h01 << idx;
    endfunction

endpackage

// File: rtl/vmba_host_seq_if.sv
// Request/response handshake bundle between a processor-side master and the sequencer.
interface vmba_host_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [1:0] req_dev;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_op, req_dev, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_dev, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/vmba_seq_timer.sv
// Loadable down-counter; 'expired' is high once the count has reached zero.
module vmba_seq_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] count_r;

    // Count register: load takes priority, otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign expired = (count_r == {W{1'b0}});
endmodule

// File: rtl/vmba_host_seq.sv
// Processor-side sequencer: turns single write/read/device-reset requests into
// timed R3CTRL/R4DATA/R5ADDR sequences towards the VMBA and returns a response.
module vmba_host_seq
    import vmba_host_seq_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned READ_WAIT  = 2
) (
    input  logic            clk,
    input  logic            rst,
    vmba_host_seq_if.slave  bus,
    output logic [7:0]      R3CTRL,
    output logic [7:0]      R4DATA,
    output logic [7:0]      R5ADDR,
    input  logic [7:0]      AMBAOUT,
    output logic            busy
);
    localparam int unsigned S_EFF = at_least_one(SETUP_CYC);
    localparam int unsigned P_EFF = at_least_one(STROBE_CYC);
    localparam int unsigned H_EFF = at_least_one(HOLD_CYC);
    localparam int unsigned R_EFF = at_least_one(READ_WAIT);
    localparam int unsigned TW    = $clog2(max4(S_EFF, P_EFF, H_EFF, R_EFF)) + 1;

    // Timer counts down to zero, so a phase of N cycles loads N-1.
    localparam logic [TW-1:0] S_LD = TW'(S_EFF - 1);
    localparam logic [TW-1:0] P_LD = TW'(P_EFF - 1);
    localparam logic [TW-1:0] H_LD = TW'(H_EFF - 1);
    localparam logic [TW-1:0] R_LD = TW'(R_EFF - 1);

    state_e        state_r;
    op_e           op_r;
    logic [7:0]    ctrl_r;
    logic [7:0]    data_r;
    logic [7:0]    addr_r;
    logic [7:0]    rdata_r;
    logic          rsp_valid_r;
    logic          rsp_err_r;
    logic          req_ready_r;
    logic          busy_r;
    logic          load_s;
    logic [TW-1:0] load_val_s;
    logic          expired_s;

    vmba_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .expired  (expired_s)
    );

    // Timer reload: preset for SETUP while idle, then for the next phase on each expiry.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = {TW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                load_s     = 1'b1;
                load_val_s = S_LD;
            end
            ST_SETUP: begin
                load_s     = expired_s;
                load_val_s = (op_r == OP_RD) ? R_LD : P_LD;
            end
            ST_STROBE: begin
                load_s     = expired_s;
                load_val_s = H_LD;
            end
            default: begin
                load_s     = 1'b0;
                load_val_s = {TW{1'b0}};
            end
        endcase
    end

    // Sequencer FSM with all bus and response outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_WR;
            ctrl_r      <= 8'h00;
            data_r      <= 8'h00;
            addr_r      <= 8'h00;
            rdata_r     <= 8'h00;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_r        <= op_e'(bus.req_op);
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        case (op_e'(bus.req_op))
                            OP_WR: begin
                                state_r <= ST_SETUP;
                                addr_r  <= {6'b000000, bus.req_dev};
                                data_r  <= bus.req_wdata;
                            end
                            OP_RD: begin
                                state_r <= ST_SETUP;
                                addr_r  <= {2'b00, bus.req_dev, 4'h0};
                                data_r  <= 8'h00;
                                ctrl_r  <= ctrl_bit(B_OE);
                            end
                            OP_RST: begin
                                state_r <= ST_SETUP;
                                addr_r  <= {6'b000000, bus.req_dev};
                                data_r  <= 8'h00;
                            end
                            default: begin
                                // Illegal op: answer with an error, never touch the bus.
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                                rsp_err_r   <= 1'b1;
                                rdata_r     <= 8'h00;
                            end
                        endcase
                    end
                end
                ST_SETUP: begin
                    if (expired_s) begin
                        if (op_r == OP_RD) begin
                            state_r <= ST_RDWAIT;
                        end else begin
                            state_r <= ST_STROBE;
                            ctrl_r  <= (op_r == OP_RST) ? ctrl_bit(B_DEVRST) : ctrl_bit(B_LD);
                        end
                    end
                end
                ST_STROBE: begin
                    if (expired_s) begin
                        state_r <= ST_HOLD;
                        ctrl_r  <= 8'h00;
                    end
                end
                ST_HOLD: begin
                    if (expired_s) begin
                        state_r     <= ST_RESP;
                        addr_r      <= 8'h00;
                        data_r      <= 8'h00;
                        rdata_r     <= 8'h00;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end
                end
                ST_RDWAIT: begin
                    if (expired_s) begin
                        state_r     <= ST_RESP;
                        ctrl_r      <= 8'h00;
                        addr_r      <= 8'h00;
                        rdata_r     <= AMBAOUT;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        rdata_r     <= 8'h00;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ctrl_r      <= 8'h00;
                    data_r      <= 8'h00;
                    addr_r      <= 8'h00;
                    rdata_r     <= 8'h00;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign R3CTRL        = ctrl_r;
    assign R4DATA        = data_r;
    assign R5ADDR        = addr_r;
    assign busy          = busy_r;
    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_vmba_host_seq.sv
// Bench for vmba_host_seq: directed and random transactions on a default instance
// and on a STROBE_CYC=4 instance, checked cycle by cycle against a timing model.
module tb_vmba_host_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       req_valid;
    logic [1:0] req_op;
    logic [1:0] req_dev;
    logic [7:0] req_wdata;
    logic       rsp_ready;
    logic [7:0] amba;
    logic [7:0] ctrl0, data0, addr0, ctrl1, data1, addr1;
    logic       busy0, busy1;
    logic [7:0] o_ctrl, o_data, o_addr, o_rdata;
    logic       o_busy, o_rv, o_err, o_rr;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    vmba_host_seq_if bus0();
    vmba_host_seq_if bus1();

    assign bus0.req_valid = req_valid & ~sel;
    assign bus1.req_valid = req_valid & sel;
    assign bus0.rsp_ready = rsp_ready & ~sel;
    assign bus1.rsp_ready = rsp_ready & sel;
    assign bus0.req_op    = req_op;
    assign bus1.req_op    = req_op;
    assign bus0.req_dev   = req_dev;
    assign bus1.req_dev   = req_dev;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_wdata = req_wdata;

    vmba_host_seq u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .R3CTRL(ctrl0), .R4DATA(data0), .R5ADDR(addr0),
        .AMBAOUT(amba), .busy(busy0)
    );

    vmba_host_seq #(.STROBE_CYC(4)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .R3CTRL(ctrl1), .R4DATA(data1), .R5ADDR(addr1),
        .AMBAOUT(amba), .busy(busy1)
    );

    assign o_ctrl  = sel ? ctrl1 : ctrl0;
    assign o_data  = sel ? data1 : data0;
    assign o_addr  = sel ? addr1 : addr0;
    assign o_busy  = sel ? busy1 : busy0;
    assign o_rv    = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign o_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    assign o_err   = sel ? bus1.rsp_err   : bus0.rsp_err;
    assign o_rr    = sel ? bus1.req_ready : bus0.req_ready;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected bus state t cycles after the accepting edge, from the phase lengths.
    task automatic model(input int t, input int lat, input int p, input logic [1:0] op,
                         input logic [1:0] dev, input logic [7:0] wd,
                         output logic [7:0] c, output logic [7:0] d,
                         output logic [7:0] a, output logic rv);
        c = 8'h00; d = 8'h00; a = 8'h00; rv = 1'b0;
        if (t >= lat) begin
            rv = 1'b1;
        end else if (op == 2'b01) begin
            c = 8'h02;
            a = {2'b00, dev, 4'h0};
        end else begin
            a = {6'b000000, dev};
            d = (op == 2'b00) ? wd : 8'h00;
            if (t >= 1 && t < 1 + p) c = (op == 2'b00) ? 8'h01 : 8'h04;
        end
    endtask

    // One complete transaction; famba[8] pins AMBAOUT, else it is random every cycle.
    task automatic do_txn(input logic s, input logic [1:0] op, input logic [1:0] dev,
                          input logic [7:0] wd, input int delay, input bit push2nd,
                          input logic [8:0] famba);
        int p;
        int lat;
        logic [7:0] hist [0:15];
        logic [7:0] ec, ed, ea, erd;
        logic erv;
        p   = s ? 4 : 2;
        lat = (op == 2'b01) ? 3 : ((op == 2'b11) ? 0 : 2 + p);
        sel = s;
        req_valid = 1'b1; req_op = op; req_dev = dev; req_wdata = wd; rsp_ready = 1'b0;
        chk1("req_ready_before_accept", o_rr, 1'b1);
        step();
        req_valid = 1'b0;
        erd = 8'h00;
        for (int t = 0; t <= lat; t++) begin
            model(t, lat, p, op, dev, wd, ec, ed, ea, erv);
            chk8("r3ctrl", o_ctrl, ec);
            chk8("r4data", o_data, ed);
            chk8("r5addr", o_addr, ea);
            chk1("rsp_valid", o_rv, erv);
            chk1("busy", o_busy, 1'b1);
            chk1("req_ready_busy", o_rr, 1'b0);
            if (t < lat) begin
                amba = famba[8] ? famba[7:0] : 8'($urandom);
                hist[t] = amba;
                step();
            end
        end
        if (op == 2'b01) erd = hist[lat - 1];
        chk8("rsp_rdata", o_rdata, erd);
        chk1("rsp_err", o_err, op == 2'b11);
        for (int k = 0; k < delay; k++) begin
            if (push2nd) begin
                req_valid = 1'b1; req_op = 2'b00; req_dev = 2'd0; req_wdata = 8'h5A;
            end
            step();
            chk1("bp_rsp_valid", o_rv, 1'b1);
            chk8("bp_rsp_rdata", o_rdata, erd);
            chk1("bp_rsp_err", o_err, op == 2'b11);
            chk1("bp_req_ready", o_rr, 1'b0);
            chk8("bp_r3ctrl", o_ctrl, 8'h00);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk1("post_rsp_valid", o_rv, 1'b0);
        chk1("post_req_ready", o_rr, 1'b1);
        chk1("post_busy", o_busy, 1'b0);
        chk8("post_r5addr", o_addr, 8'h00);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_dev = 2'd0;
        req_wdata = 8'h00; rsp_ready = 1'b0; amba = 8'h00;
        #12;
        chk8("reset_r3ctrl", o_ctrl, 8'h00);
        chk8("reset_r4data", o_data, 8'h00);
        chk8("reset_r5addr", o_addr, 8'h00);
        chk1("reset_rsp_valid", o_rv, 1'b0);
        chk1("reset_busy", o_busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk1("release_req_ready", o_rr, 1'b1);
        chk8("release_rdata", o_rdata, 8'h00);
        chk1("release_err", o_err, 1'b0);

        // Write dev2 A5, read dev1 3C, backpressured read with a pending second request.
        do_txn(1'b0, 2'b00, 2'd2, 8'hA5, 0, 1'b0, 9'h000);
        do_txn(1'b0, 2'b01, 2'd1, 8'h00, 0, 1'b0, 9'h13C);
        do_txn(1'b0, 2'b01, 2'd2, 8'h00, 6, 1'b1, 9'h000);
        do_txn(1'b0, 2'b00, 2'd0, 8'h5A, 0, 1'b0, 9'h000);
        do_txn(1'b0, 2'b11, 2'd1, 8'hFF, 2, 1'b0, 9'h000);
        // Long strobe instance: device reset dev3 then back-to-back write.
        do_txn(1'b1, 2'b10, 2'd3, 8'h77, 0, 1'b0, 9'h000);
        do_txn(1'b1, 2'b00, 2'd1, 8'hC3, 1, 1'b0, 9'h000);

        // Reset in the middle of a write strobe.
        sel = 1'b0;
        req_valid = 1'b1; req_op = 2'b00; req_dev = 2'd1; req_wdata = 8'h77;
        step();
        req_valid = 1'b0;
        step();
        chk8("pre_abort_ld", o_ctrl, 8'h01);
        #2 rst = 1'b0;
        #1;
        chk8("abort_r3ctrl", o_ctrl, 8'h00);
        chk8("abort_r4data", o_data, 8'h00);
        chk8("abort_r5addr", o_addr, 8'h00);
        chk1("abort_rsp_valid", o_rv, 1'b0);
        chk1("abort_busy", o_busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk1("abort_no_stale_rsp", o_rv, 1'b0);
            chk1("abort_req_ready", o_rr, 1'b1);
            chk8("abort_idle_r3ctrl", o_ctrl, 8'h00);
        end

        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)),
                   1'b0, 9'h000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
